lcg_stim_gen: RTL and testbench

Synthesizable upstream stimulus source for fuzz harnesses. It produces the wide flat input vector of the design under test using the harness's 32-bit LCG: multiplier 0x41C64E6D, increment 0x3039, 32-bit chunks filled LSB-first, last chunk truncated to its low bits. A trace and compare stage consumes its output through a valid/ready handshake. It replaces behavioural stimulus loops, so emulation and simulator runs see bit-identical vector streams.

---
 rtl/lcg_stim_gen_if.sv | 23 ++
 rtl/lcg_stim_gen.sv | 140 ++++++++++++++
 tb/tb_lcg_stim_gen.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/lcg_stim_gen_if.sv
// Vector stream handshake between lcg_stim_gen (master) and its consumer (slave).
interface lcg_stim_gen_if #(
  parameter int unsigned OUT_W = 265
) ();
  logic             vec_valid;
  logic             vec_ready;
  logic [OUT_W-1:0] vec_data;
  logic [31:0]      vec_index;

  modport master (
    output vec_valid,
    output vec_data,
    output vec_index,
    input  vec_ready
  );

  modport slave (
    input  vec_valid,
    input  vec_data,
    input  vec_index,
    output vec_ready
  );
endinterface

// File: rtl/lcg_stim_gen.sv
// LCG-driven stimulus vector source with a valid/ready output stream.
// Define LCG_STIM_GEN_PARALLEL_EN to build each vector in one cycle instead of one chunk per cycle.
module lcg_stim_gen #(
  parameter int unsigned OUT_W       = 265,
  parameter int unsigned NUM_VECTORS = 100
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [31:0]    seed_in,
  lcg_stim_gen_if.master vec,
  output logic           busy,
  output logic           done
);

  localparam int unsigned N         = (OUT_W + 31) / 32;
  localparam int unsigned PadW      = N * 32;
  localparam logic [31:0] LastIndex = 32'(NUM_VECTORS - 1);
  localparam logic [31:0] LcgMul    = 32'h41C64E6D;
  localparam logic [31:0] LcgInc    = 32'h0000_3039;

  typedef enum logic [1:0] {StIdle, StFill, StPresent, StDone} state_e;

  state_e           st_q;
  logic [31:0]      lcg_q;
  logic [31:0]      lcg_next;
  logic [OUT_W-1:0] data_q;
  logic [PadW-1:0]  fill_pad;
  logic             fill_last;
  logic             valid_q;
  logic [31:0]      index_q;
  logic             busy_q;
  logic             done_q;

  function automatic logic [31:0] lcg_step(input logic [31:0] s);
    return s * LcgMul + LcgInc;
  endfunction

`ifdef LCG_STIM_GEN_PARALLEL_EN
  // All N steps chained combinationally; the vector lands in a single FILL cycle.
  logic [31:0] chain [N+1];

  assign chain[0] = lcg_q;
  for (genvar k = 0; k < N; k++) begin : g_chain
    assign chain[k+1]           = lcg_step(chain[k]);
    assign fill_pad[32*k +: 32] = chain[k+1];
  end

  assign lcg_next  = chain[N];
  assign fill_last = 1'b1;
`else
  localparam int unsigned CntW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastChunk = CntW'(N - 1);

  logic [CntW-1:0] chunk_q;

  assign lcg_next  = lcg_step(lcg_q);
  assign fill_last = (chunk_q == LastChunk);

  always_comb begin
    fill_pad = PadW'(data_q);
    fill_pad[int'(chunk_q) * 32 +: 32] = lcg_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chunk_q <= '0;
    end else if (st_q == StFill && !fill_last) begin
      chunk_q <= chunk_q + 1'b1;
    end else begin
      chunk_q <= '0;
    end
  end
`endif

  // Bits above OUT_W in the last chunk are truncated away.
  if (PadW > OUT_W) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^fill_pad[PadW-1:OUT_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= StIdle;
      lcg_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      index_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (st_q)
        StIdle, StDone: begin
          if (start) begin
            lcg_q   <= seed_in;
            index_q <= '0;
            if (NUM_VECTORS == 0) begin
              st_q   <= StDone;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              st_q   <= StFill;
              busy_q <= 1'b1;
              done_q <= 1'b0;
            end
          end
        end
        StFill: begin
          lcg_q  <= lcg_next;
          data_q <= fill_pad[OUT_W-1:0];
          if (fill_last) begin
            st_q    <= StPresent;
            valid_q <= 1'b1;
          end
        end
        StPresent: begin
          if (vec.vec_ready) begin
            valid_q <= 1'b0;
            if (index_q == LastIndex) begin
              st_q   <= StDone;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              index_q <= index_q + 32'd1;
              st_q    <= StFill;
            end
          end
        end
        default: st_q <= StIdle;
      endcase
    end
  end

  assign vec.vec_valid = valid_q;
  assign vec.vec_data  = data_q;
  assign vec.vec_index = index_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_lcg_stim_gen.sv
// Scoreboard bench for lcg_stim_gen: reference LCG stream, backpressure, abort and empty-run cases.
module tb_lcg_stim_gen;

  localparam int unsigned OUT_W = 265;
  localparam int unsigned NV    = 100;
  localparam int unsigned N     = (OUT_W + 31) / 32;
`ifdef LCG_STIM_GEN_PARALLEL_EN
  localparam int FillCyc = 1;
`else
  localparam int FillCyc = N;
`endif

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        start  = 1'b0;
  logic        start0 = 1'b0;
  logic [31:0] seed   = '0;
  logic [31:0] seed0  = '0;
  logic        busy, done, busy0, done0;

  lcg_stim_gen_if #(.OUT_W(OUT_W)) vif  ();
  lcg_stim_gen_if #(.OUT_W(OUT_W)) vif0 ();

  lcg_stim_gen #(.OUT_W(OUT_W), .NUM_VECTORS(NV)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .seed_in (seed),
    .vec     (vif),
    .busy    (busy),
    .done    (done)
  );

  lcg_stim_gen #(.OUT_W(OUT_W), .NUM_VECTORS(0)) dut0 (
    .clk     (clk),
    .rst     (rst),
    .start   (start0),
    .seed_in (seed0),
    .vec     (vif0),
    .busy    (busy0),
    .done    (done0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [31:0]      idx;
  } exp_t;

  exp_t             exp_q[$];
  int               total = 0;
  int               bad = 0;
  int               cyc = 0;
  int               last_hs = -1;
  int               hs_cnt = 0;
  logic             tput_on = 1'b0;
  logic             pend = 1'b0;
  logic [OUT_W-1:0] pend_data;
  logic             saw_valid0 = 1'b0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] lcg(input logic [31:0] s);
    return s * 32'h41C64E6D + 32'h3039;
  endfunction

  // Reference stream: N consecutive LCG outputs per vector, packed LSB-first, state carried over.
  task automatic push_run(input logic [31:0] sd);
    logic [31:0]     s = sd;
    logic [N*32-1:0] w;
    exp_t            e;
    exp_q.delete();
    for (int v = 0; v < NV; v++) begin
      for (int k = 0; k < N; k++) begin
        s = lcg(s);
        w[32*k +: 32] = s;
      end
      e.data = w[OUT_W-1:0];
      e.idx  = v;
      exp_q.push_back(e);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: checks every handshake against the scoreboard and data hold under backpressure.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (vif0.vec_valid) saw_valid0 = 1'b1;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) chk("hold_data", vif.vec_data, pend_data);
      if (vif.vec_valid && vif.vec_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_vec: got index %0d want none", vif.vec_index);
        end else begin
          e = exp_q.pop_front();
          chk("vec_data", vif.vec_data, e.data);
          chk("vec_index", vif.vec_index, e.idx);
        end
        if (tput_on && last_hs >= 0) chk("hs_gap", cyc - last_hs, FillCyc + 1);
        last_hs = cyc;
      end
      pend      = vif.vec_valid && !vif.vec_ready;
      pend_data = vif.vec_data;
    end
  end

  task automatic start_run(input logic [31:0] sd, input logic [31:0] first_chunk);
    int c0;
    int n = 0;
    last_hs = -1;
    hs_cnt  = 0;
    seed    = sd;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c0    = cyc;
    chk("busy_after_start", busy, 1);
    while (!vif.vec_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("fill_latency", cyc - c0, FillCyc);
    chk("first_chunk", vif.vec_data[31:0], first_chunk);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done", done, 1);
    chk("done_after_last_hs", cyc - last_hs, 1);
    chk("valid_at_done", vif.vec_valid, 0);
    chk("busy_at_done", busy, 0);
    chk("final_index", vif.vec_index, NV - 1);
    chk("handshakes", hs_cnt, NV);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, vif.vec_valid, 0);
    chk({tag, "_data"}, vif.vec_data, 0);
    chk({tag, "_index"}, vif.vec_index, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    int n;
    vif.vec_ready  = 1'b0;
    vif0.vec_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Seed 0, ready tied high.
    push_run(32'd0);
    tput_on       = 1'b1;
    vif.vec_ready = 1'b1;
    start_run(32'd0, 32'h0000_3039);
    chk("second_chunk", vif.vec_data[63:32], 32'hD3DC_167E);
    wait_done();

    // Seed 1 with random backpressure and ignored start pulses while busy.
    push_run(32'd1);
    tput_on       = 1'b0;
    vif.vec_ready = 1'b0;
    start_run(32'd1, 32'h41C6_7EA6);
    n = 0;
    while (n < 20000 && !done) begin
      vif.vec_ready = ($urandom_range(0, 9) >= 3);
      start         = busy && ($urandom_range(0, 7) == 0);
      @(posedge clk); #1;
      n++;
    end
    start         = 1'b0;
    vif.vec_ready = 1'b1;
    wait_done();

    // Abort mid-FILL of vector 5, then rerun seed 0.
    push_run(32'd0);
    tput_on = 1'b1;
    start_run(32'd0, 32'h0000_3039);
    n = 0;
    while (!(vif.vec_index == 5 && busy && !vif.vec_valid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reached_fill5", vif.vec_index, 5);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("abort");
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("no_valid_after_abort", vif.vec_valid, 0);
    push_run(32'd0);
    start_run(32'd0, 32'h0000_3039);
    wait_done();

    // Empty run: done the cycle after start, never valid.
    chk("nv0_idle_done", done0, 0);
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    chk("nv0_done", done0, 1);
    chk("nv0_busy", busy0, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("nv0_never_valid", saw_valid0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
